// File: rtl/status_banner_ctrl.sv
// Status banner sequencer: picks the banner sprite, blinks it on banner changes, gates its screen region.
// Latency: rom_address/banner_on 1 cycle after DrawX/DrawY; banner_sel updates the cycle after frame_tick.
// Backpressure: none; a free-running pixel pipeline that accepts one pixel per vga_clk.
module status_banner_ctrl #(
    parameter int unsigned X0            = 560,
    parameter int unsigned Y0            = 434,
    parameter int unsigned W             = 80,
    parameter int unsigned H             = 45,
    parameter int unsigned HALF_PERIOD   = 15,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        turn_black,
    input  logic        in_check,
    input  logic        game_over,
    output logic [1:0]  banner_sel,
    output logic        banner_on,
    output logic [11:0] rom_address,
    output logic        frame_tick
);

    localparam int unsigned FW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned TW = $clog2(FLASH_TOGGLES + 1);

    localparam logic [9:0] X0_L = 10'(X0);
    localparam logic [9:0] X1_L = 10'(X0 + W - 1);
    localparam logic [9:0] Y0_L = 10'(Y0);
    localparam logic [9:0] Y1_L = 10'(Y0 + H - 1);
    localparam logic [9:0] VBLANK_ROW = 10'd480;

    localparam logic [FW-1:0] HALF_LAST   = FW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_DONE = TW'(FLASH_TOGGLES);

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_FLASH  = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    state_t          state;
    state_t          reload_state;
    logic            reload;
    logic            visible;
    logic [FW-1:0]   frame_cnt;
    logic [TW-1:0]   toggle_cnt;
    logic            vblank;
    logic            vblank_q;
    logic [1:0]      desired;
    logic            half_done;
    logic            in_region;
    logic [9:0]      dx;
    logic [9:0]      dy;
    logic [11:0]     pix_addr;

    assign vblank    = (DrawY >= VBLANK_ROW);
    assign desired   = game_over ? 2'd3 : (in_check ? 2'd2 : {1'b0, turn_black});
    assign half_done = (frame_cnt == HALF_LAST);

    assign in_region = (DrawX >= X0_L) && (DrawX <= X1_L) &&
                       (DrawY >= Y0_L) && (DrawY <= Y1_L);
    assign dx        = DrawX - X0_L;
    assign dy        = DrawY - Y0_L;
    assign pix_addr  = 12'(dx) + 12'(dy) * 12'(W);

    // A new code always wins over a pending toggle on the same tick.
    always_comb begin
        reload       = 1'b0;
        reload_state = ST_FLASH;
        case (state)
            ST_STEADY, ST_FLASH: begin
                if (desired == 2'd3) begin
                    reload       = 1'b1;
                    reload_state = ST_OVER;
                end else if (desired != banner_sel) begin
                    reload       = 1'b1;
                    reload_state = ST_FLASH;
                end
            end
            ST_OVER: begin
                if (!game_over) begin
                    reload       = 1'b1;
                    reload_state = ST_FLASH;
                end
            end
            default: begin
                reload       = 1'b1;
                reload_state = ST_FLASH;
            end
        endcase
    end

    // vblank_q resets high so a tick needs a genuine vblank rising edge after reset.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vblank_q   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            frame_tick <= vblank & ~vblank_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= ST_STEADY;
            banner_sel <= 2'd0;
            visible    <= 1'b1;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
        end else if (frame_tick) begin
            if (reload) begin
                state      <= reload_state;
                banner_sel <= desired;
                visible    <= 1'b0;
                frame_cnt  <= '0;
                toggle_cnt <= TW'(1);
            end else if (state == ST_STEADY) begin
                visible <= 1'b1;
            end else if (half_done) begin
                frame_cnt <= '0;
                visible   <= ~visible;
                // Flash ends on the toggle that makes it visible for the last time.
                if (state == ST_FLASH) begin
                    toggle_cnt <= toggle_cnt + 1'b1;
                    if ((toggle_cnt + 1'b1 == TOGGLE_DONE) && !visible) begin
                        state <= ST_STEADY;
                    end
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            banner_on   <= 1'b0;
            rom_address <= '0;
        end else begin
            banner_on   <= in_region & visible & blank;
            rom_address <= in_region ? pix_addr : 12'd0;
        end
    end

endmodule
